// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory stage: opcodes, FSM encoding and
// the latched request record.
package data_mem_ctrl_pkg;
  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        rw;    // 1 = load, 0 = store
    logic [31:0] addr;
  } dmem_req_t;
endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge Clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: one access at a time against dmem_array with
// WAIT_CYCLES extra access cycles and a busy/done handshake.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              RW,
  input  logic [31:0]       add_bus,
  input  logic [DATA_W-1:0] data_bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              addr_err
);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  dmem_state_e       state, state_nxt;
  dmem_req_t         req_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic              accept, commit, oor, rd_early;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign oor = (req_q.addr >> ADDR_W) != 32'd0;

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    addr_err  = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy = 1'b1;
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        busy      = 1'b1;
        done      = 1'b1;
        addr_err  = err_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The RAM read is registered, so launch it one edge before the commit edge.
  always_comb begin
    if (WAIT_CYCLES == 0) rd_early = accept & RW;
    else                  rd_early = (state == ST_ACCESS) && (cnt == CNT_W'(1)) && req_q.rw;
  end

  assign ram_we   = commit & ~req_q.rw & ~oor & ~Reset;
  assign ram_en   = ram_we | rd_early;
  assign ram_addr = (state == ST_IDLE) ? add_bus[ADDR_W-1:0] : req_q.addr[ADDR_W-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_q   <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      rd_data <= '0;
    end else begin
      if (accept) begin
        req_q   <= '{rw: RW, addr: add_bus};
        wdata_q <= data_bus;
        cnt     <= CNT_W'(WAIT_CYCLES);
      end else if (state == ST_ACCESS && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit) begin
        err_q <= oor;
        if (req_q.rw && !oor) rd_data <= ram_rdata;
      end
    end
  end

  dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .Clk   (Clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Drives a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance from one shared input
// bus and checks both against an elapsed-time behavioural model every cycle.
module tb_data_mem_ctrl;
  logic        Clk, Reset, req, RW;
  logic [31:0] add_bus, data_bus;
  logic        busy2, done2, err2, busy0, done0, err0;
  logic [31:0] rd2, rd0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  data_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .req(req), .RW(RW), .add_bus(add_bus),
    .data_bus(data_bus), .busy(busy2), .done(done2), .rd_data(rd2), .addr_err(err2));

  data_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .req(req), .RW(RW), .add_bus(add_bus),
    .data_bus(data_bus), .busy(busy0), .done(done0), .rd_data(rd0), .addr_err(err0));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pre(input int i);
    return 32'(i) * 32'h9E3779B1;
  endfunction

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Model: t = edges since acceptance (-1 when idle). ACCESS spans t=0..W,
  // done at t=W+1, where the access effect has just been applied.
  int          t   [2] = '{-1, -1};
  logic        lrw [2];
  logic [31:0] la  [2];
  logic [31:0] ld  [2];
  logic [31:0] erd [2];
  logic        eerr[2];
  logic [31:0] mm  [2][256];
  logic [1:0]  obusy, odone, oerr;
  logic [31:0] ord [2];

  assign obusy  = {busy0, busy2};
  assign odone  = {done0, done2};
  assign oerr   = {err0, err2};
  assign ord[0] = rd2;
  assign ord[1] = rd0;

  always @(posedge Clk) begin
    for (int d = 0; d < 2; d++) begin
      if (Reset) begin
        t[d] = -1; erd[d] = '0; eerr[d] = 1'b0;
      end else if (t[d] < 0) begin
        if (req) begin
          t[d] = 0; lrw[d] = RW; la[d] = add_bus; ld[d] = data_bus;
        end
      end else begin
        t[d]++;
        if (t[d] == wc(d) + 1) begin
          eerr[d] = la[d] >= 32'd256;
          if (!eerr[d]) begin
            if (lrw[d]) erd[d] = mm[d][la[d][7:0]];
            else        mm[d][la[d][7:0]] = ld[d];
          end
        end else if (t[d] == wc(d) + 2) begin
          t[d] = -1;
        end
      end
    end
    #1;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("m%0d_busy", d), 32'(obusy[d]), 32'(t[d] >= 0));
        chk($sformatf("m%0d_done", d), 32'(odone[d]), 32'(t[d] == wc(d) + 1));
        chk($sformatf("m%0d_err", d), 32'(oerr[d]), 32'((t[d] == wc(d) + 1) && eerr[d]));
        chk($sformatf("m%0d_rd", d), ord[d], erd[d]);
      end
    end
  end

  logic [7:0] b2, d2, e2, d0;

  // Called on a negedge with both instances idle; bit k = cycle k+1 after accept.
  task automatic one_shot(input logic rw, input logic [31:0] a, input logic [31:0] dt);
    req = 1'b1; RW = rw; add_bus = a; data_bus = dt;
    @(negedge Clk);
    req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b2[k] = busy2; d2[k] = done2; e2[k] = err2; d0[k] = done0;
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset = 1'b1; req = 1'b0; RW = 1'b0; add_bus = '0; data_bus = '0;
    @(negedge Clk); @(negedge Clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_done", 32'(done2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_rd", rd2, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 256; i++) one_shot(1'b0, 32'(i), pre(i));
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;

    // write 0x05
    one_shot(1'b0, 32'h05, 32'hDEADBEEF);
    chk("t1_busy", 32'(b2), 32'h0F);
    chk("t1_done", 32'(d2), 32'h08);
    chk("t1_err", 32'(e2), 32'h00);
    chk("t1_rd", rd2, 32'd0);
    chk("t1_done_w0", 32'(d0), 32'h02);

    // read back
    one_shot(1'b1, 32'h05, 32'h0);
    chk("t2_done", 32'(d2), 32'h08);
    chk("t2_rd", rd2, 32'hDEADBEEF);
    chk("t2_rd_w0", rd0, 32'hDEADBEEF);

    // out of range
    one_shot(1'b1, 32'h100, 32'h0);
    chk("t3_done", 32'(d2), 32'h08);
    chk("t3_err", 32'(e2), 32'h08);
    chk("t3_rd_held", rd2, 32'hDEADBEEF);
    one_shot(1'b1, 32'h00, 32'h0);
    chk("t3_rd0", rd2, 32'd0);

    // held req, inputs change while busy
    req = 1'b1; RW = 1'b0; add_bus = 32'h07; data_bus = 32'h11111111;
    @(negedge Clk);
    add_bus = 32'h08; data_bus = 32'h22222222;
    for (int k = 0; k < 8; k++) begin
      b2[k] = busy2;
      @(negedge Clk);
    end
    req = 1'b0;
    repeat (8) @(negedge Clk);
    chk("t4_period", 32'(b2), 32'hEF);
    one_shot(1'b1, 32'h07, 32'h0);
    chk("t4_rd7", rd2, 32'h11111111);

    // reset in the second ACCESS cycle
    req = 1'b1; RW = 1'b0; add_bus = 32'h09; data_bus = 32'hCAFEF00D;
    @(negedge Clk);
    req = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("t5_busy", 32'(busy2), 32'd0);
    chk("t5_done", 32'(done2), 32'd0);
    Reset = 1'b0;
    d2 = '0;
    for (int k = 0; k < 6; k++) begin
      d2[k] = done2;
      @(negedge Clk);
    end
    chk("t5_no_done", 32'(d2), 32'h00);
    one_shot(1'b1, 32'h09, 32'h0);
    chk("t5_rd9", rd2, pre(9));
    chk("t5_rd9_w0", rd0, 32'hCAFEF00D);

    // zero wait states
    one_shot(1'b0, 32'h03, 32'hA5A5A5A5);
    chk("t6_wdone", 32'(d0), 32'h02);
    one_shot(1'b1, 32'h03, 32'h0);
    chk("t6_rdone", 32'(d0), 32'h02);
    chk("t6_rd", rd0, 32'hA5A5A5A5);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      Reset    = ($urandom_range(63) == 0);
      req      = $urandom_range(1);
      RW       = $urandom_range(1);
      add_bus  = ($urandom_range(7) == 0) ? $urandom : 32'($urandom_range(255));
      data_bus = $urandom;
      @(negedge Clk);
    end
    Reset = 1'b0; req = 1'b0;
    repeat (10) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory stage directly downstream of the memory control block. It consumes the address bus, store data bus and read/write select that block produces, and runs one access at a time against an internal single-port word RAM with configurable wait states. It returns load data for the register writeback path, with a busy/done handshake so the core can stall.

Parameters:
ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W
DATA_W, 32, data word width
WAIT_CYCLES, 2, extra access cycles before the RAM operation commits (0 allowed)

Ports:
Clk  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
req  input  1  access request, sampled only in IDLE
RW  input  1  1 = read (LDR), 0 = write (STR)
add_bus  input  32  word address from memory control
data_bus  input  DATA_W  store data from memory control
busy  output  1  high while an access is in flight
done  output  1  one-cycle completion pulse
rd_data  output  DATA_W  last successful load data, held
addr_err  output  1  pulses with done when the address is out of range

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset (sampled high at an edge):
  - FSM goes to IDLE; busy=0, done=0, addr_err=0, rd_data=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-access aborts it: a pending write is not committed, and no done is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - busy=0, done=0.
  - If req=1 at an edge: latch RW, add_bus and data_bus into internal registers, load counter=WAIT_CYCLES, go to ACCESS.
  - If req=0: stay in IDLE.
- ACCESS:
  - busy=1.
  - If counter != 0: decrement and stay.
  - If counter == 0:
    - Error case, latched add_bus[31:ADDR_W] != 0: set addr_err, no RAM read or write, rd_data unchanged.
    - Read: rd_data <= RAM[addr[ADDR_W-1:0]].
    - Write: RAM[addr] <= latched data.
    - Then go to RESP.
- RESP:
  - busy=1, done=1 for exactly one cycle; addr_err is valid this cycle only.
  - Next state is IDLE.
- Latency:
  - req sampled at edge N gives ACCESS for cycles N+1..N+1+WAIT_CYCLES and done high in cycle N+2+WAIT_CYCLES.
  - Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- req is ignored in ACCESS and RESP; it is not queued. Upstream must hold req until it sees busy=0 in IDLE.
- Inputs changing after acceptance have no effect (latched copy is used).
- rd_data changes only on a successful read completion. Writes and errored reads leave it unchanged.
- Read-after-write to the same address in consecutive accesses returns the newly written value.
- Address wrap: none. Out-of-range addresses error; they are not truncated.
- WAIT_CYCLES=0: ACCESS lasts one cycle and done arrives at cycle N+2.

Decomposition:
- Shared package holds:
  - opcode constants OP_LDR=4'b1101 and OP_STR=4'b1110 (used by memory control and decode);
  - the state encoding for IDLE/ACCESS/RESP;
  - default DATA_W=32.
- One natural sub-module, dmem_array: a single-port synchronous RAM of 2**ADDR_W x DATA_W. Inputs are we, en, addr and wdata; output is a registered rdata. The FSM, counter and error check stay in data_mem_ctrl.
- Account for dmem_array's registered read. Either have the array's read enable one cycle early (counter==1, or the accept edge when WAIT_CYCLES=0), or add one internal cycle. Whichever is chosen, the external latency above is fixed.

Test Plan:
1. WAIT_CYCLES=2; write sequence:
   - Reset, then req=1, RW=0, add_bus=0x05, data_bus=0xDEADBEEF at edge 0.
   - Required: busy=1 in cycles 1-4, done=1 only in cycle 4, addr_err=0, rd_data stays 0.
2. Read-back:
   - After test 1, req=1, RW=1, add_bus=0x05.
   - Required: done 4 cycles after acceptance, rd_data=0xDEADBEEF from the done cycle on, held until the next read.
3. Out-of-range read:
   - req read with add_bus=0x00000100.
   - Required: done and addr_err both pulse in the same cycle, rd_data unchanged (0xDEADBEEF), no RAM change.
   - Follow-up read of 0x00 returns 0.
4. Busy ignore:
   - Hold req=1 continuously with a write to 0x07 = 0x11111111.
   - While busy, change add_bus to 0x08 and data_bus to 0x22222222.
   - Required: only RAM[0x07]=0x11111111 is written. The next acceptance occurs in the first IDLE cycle after done, i.e. 5-cycle period.
5. Reset mid-access:
   - Start a write of 0xCAFEF00D to 0x09; assert Reset in the second ACCESS cycle.
   - Required: busy=0 and done=0 the next cycle, no done pulse, and a read of 0x09 returns the prior value.
6. WAIT_CYCLES=0 build:
   - Write 0x3 -> 0xA5A5A5A5, then read 0x3.
   - Required: each done arrives 2 cycles after acceptance, and rd_data=0xA5A5A5A5.
